// File: rtl/move_dispatcher.sv
// Move dispatcher: owns the falling tile's position, queues key and gravity
// move commands, hands them one at a time to the move executor and commits
// the position it returns. A rejected gravity down-move lands the tile and
// halts the block until the next spawn.

package move_dispatcher_pkg;
  typedef enum logic [1:0] {
    eUp    = 2'd0,
    eDown  = 2'd1,
    eLeft  = 2'd2,
    eRight = 2'd3
  } direction_e;
endpackage

module move_dispatcher
  import move_dispatcher_pkg::*;
#(
  parameter int width_p          = 16,
  parameter int height_p         = 32,
  parameter int fifo_depth_p     = 4,
  parameter int gravity_period_p = 1024,
  localparam int x_w_lp          = $clog2(width_p),
  localparam int y_w_lp          = $clog2(height_p),
  localparam int pt_w_lp         = x_w_lp + y_w_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               key_v_i,
  input  direction_e         key_dir_i,
  input  logic               spawn_v_i,
  input  logic [pt_w_lp-1:0] spawn_pos_i,
  input  logic               gravity_en_i,
  output logic               exec_v_o,
  output direction_e         exec_dir_o,
  input  logic               exec_done_i,
  input  logic               exec_data_v_i,
  input  logic [pt_w_lp-1:0] exec_new_pos_i,
  output logic [pt_w_lp-1:0] pos_o,
  output logic               landed_o,
  output logic               halted_o,
  output logic               fifo_full_o,
  output logic [7:0]         drop_cnt_o
);

  localparam int ptr_w_lp = $clog2(fifo_depth_p);
  localparam int cnt_w_lp = $clog2(gravity_period_p);
  localparam logic [cnt_w_lp-1:0] grav_last_lp  = cnt_w_lp'(gravity_period_p - 1);
  localparam logic [ptr_w_lp:0]   fifo_depth_lp = (ptr_w_lp + 1)'(fifo_depth_p);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e state_r, state_next_s;

  // Command FIFO: entry = {dir[1:0], grav_tag}
  logic [2:0]          fifo_mem_r [fifo_depth_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [ptr_w_lp:0]   count_r;

  logic [cnt_w_lp-1:0] grav_cnt_r;
  logic                grav_pend_r;
  logic                first_r, tag_r, acc_r, stale_r;
  logic [pt_w_lp-1:0]  pos_r;
  logic                halted_r, landed_r;
  logic [7:0]          drop_cnt_r;

  logic       empty_s, full_s;
  logic [2:0] head_s;
  logic       head_tag_s;
  direction_e head_dir_s;
  logic       exec_v_s, land_s, wait_done_s;
  logic       pop_s, key_req_s, slot_s, key_push_s, grav_push_s, push_s, drop_s;
  logic       flush_s, tick_s;
  logic [2:0] push_data_s;

  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == fifo_depth_lp);
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign head_dir_s = direction_e'(head_s[2:1]);
  assign head_tag_s = head_s[0];

  // FSM next state, issue strobe and landing decision
  always_comb begin
    state_next_s = state_r;
    exec_v_s     = 1'b0;
    land_s       = 1'b0;
    wait_done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        exec_v_s = !empty_s && exec_done_i && !halted_r && !spawn_v_i;
        if (exec_v_s) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_WAIT: begin
        // done is still the stale idle level during the executor's judge cycle
        if (!first_r && exec_done_i) begin
          state_next_s = S_IDLE;
          wait_done_s  = 1'b1;
          land_s       = !acc_r && tag_r && !stale_r && !spawn_v_i;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Push arbitration: key beats gravity, a same-cycle pop frees a slot
  always_comb begin
    pop_s       = exec_v_s;
    key_req_s   = key_v_i && !halted_r && !spawn_v_i;
    slot_s      = !full_s || pop_s;
    key_push_s  = 1'b0;
    grav_push_s = 1'b0;
    drop_s      = 1'b0;
    if (key_req_s) begin
      if (slot_s) begin
        key_push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      grav_push_s = grav_pend_r && slot_s && !spawn_v_i;
    end
    push_s = key_push_s || grav_push_s;
    if (key_push_s) begin
      push_data_s = {key_dir_i, 1'b0};
    end else begin
      push_data_s = {eDown, 1'b1};
    end
    flush_s = spawn_v_i || land_s;
    tick_s  = gravity_en_i && !halted_r && (grav_cnt_r == grav_last_lp);
  end

  // Command FIFO pointers and storage; spawn and landing discard everything queued
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r             <= wr_ptr_r + ptr_w_lp'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (ptr_w_lp + 1)'(1'b1);
        2'b01:   count_r <= count_r - (ptr_w_lp + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Gravity period counter and pending-tick flag (repeat ticks merge)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grav_cnt_r  <= '0;
      grav_pend_r <= 1'b0;
    end else if (spawn_v_i) begin
      grav_cnt_r  <= '0;
      grav_pend_r <= 1'b0;
    end else begin
      if (gravity_en_i && !halted_r) begin
        if (tick_s) begin
          grav_cnt_r <= '0;
        end else begin
          grav_cnt_r <= grav_cnt_r + cnt_w_lp'(1'b1);
        end
      end
      if (land_s) begin
        grav_pend_r <= 1'b0;
      end else if (tick_s) begin
        grav_pend_r <= 1'b1;
      end else if (grav_push_s) begin
        grav_pend_r <= 1'b0;
      end
    end
  end

  // FSM state, in-flight command context, committed position and halt/land flags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= S_IDLE;
      first_r  <= 1'b0;
      tag_r    <= 1'b0;
      acc_r    <= 1'b0;
      stale_r  <= 1'b0;
      pos_r    <= '0;
      halted_r <= 1'b1;
      landed_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      landed_r <= land_s;
      first_r  <= exec_v_s;
      if (exec_v_s) begin
        tag_r <= head_tag_s;
        acc_r <= 1'b0;
      end else if ((state_r == S_WAIT) && exec_data_v_i && !stale_r && !spawn_v_i) begin
        acc_r <= 1'b1;
      end
      if (spawn_v_i) begin
        pos_r <= spawn_pos_i;
      end else if ((state_r == S_WAIT) && exec_data_v_i && !stale_r) begin
        pos_r <= exec_new_pos_i;
      end
      if (spawn_v_i) begin
        halted_r <= 1'b0;
      end else if (land_s) begin
        halted_r <= 1'b1;
      end
      // a spawn during an in-flight command orphans the executor's answer
      if (wait_done_s) begin
        stale_r <= 1'b0;
      end else if (spawn_v_i && (state_r == S_WAIT)) begin
        stale_r <= 1'b1;
      end
    end
  end

  // Saturating count of key requests lost to a full FIFO
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign exec_v_o    = exec_v_s;
  assign exec_dir_o  = head_dir_s;
  assign pos_o       = pos_r;
  assign landed_o    = landed_r;
  assign halted_o    = halted_r;
  assign fifo_full_o = full_s;
  assign drop_cnt_o  = drop_cnt_r;

endmodule
